// File: rtl/shift_register_if.sv
// shift_register_if
//   Bundles the data-path signals of shift_register.
//   o_q    : current register contents (driven by the register)
//   i_d    : parallel load word
//   i_load : parallel load enable, takes priority over shifting
//   i_s    : serial input bit, enters at the MSB on a shift
// Modports:
//   master : the environment driving load/shift inputs and observing o_q
//   slave  : the shift register itself
interface shift_register_if #(
    parameter int unsigned BW_DATA = 8
);
    logic [BW_DATA-1:0] o_q;
    logic [BW_DATA-1:0] i_d;
    logic               i_load;
    logic               i_s;

    modport master (
        output i_d,
        output i_load,
        output i_s,
        input  o_q
    );

    modport slave (
        input  i_d,
        input  i_load,
        input  i_s,
        output o_q
    );
endinterface

// File: rtl/shift_register.sv
// shift_register
//   Parallel-load, serial-in/parallel-out register of BW_DATA bits.
//   On each rising i_clk edge it either captures bus.i_d (bus.i_load = 1)
//   or shifts right by one with bus.i_s entering at the MSB. There is no
//   hold mode: every cycle without a load is a shift.
// Ports:
//   i_clk : clock, rising edge active
//   i_rst : asynchronous active-high reset, forces contents to RST_VAL
//   bus   : shift_register_if slave (o_q, i_d, i_load, i_s)
module shift_register #(
    parameter int unsigned        BW_DATA = 8,
    parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    shift_register_if.slave  bus
);

    logic [BW_DATA-1:0] q_q;
    logic [BW_DATA-1:0] q_d;

    // Load wins over shift; i_s only ever reaches the MSB, i_d only matters
    // on a load, so an X on either is confined accordingly.
    always_comb begin
        q_d = {bus.i_s, q_q[BW_DATA-1:1]};
        if (bus.i_load) begin
            q_d = bus.i_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Output comes straight from the flops; no input-to-output path.
    assign bus.o_q = q_q;

endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register
//   Directed bench for shift_register (BW_DATA = 8, RST_VAL = 0). Inputs are
//   driven on the falling edge, outputs sampled 1 time unit after the rising
//   edge, or between edges for the asynchronous reset checks.
module tb_shift_register;

    localparam int unsigned BW = 8;

    logic i_clk;
    logic i_rst;

    int checks;
    int errors;

    logic [BW-1:0] mdl;

    shift_register_if #(.BW_DATA(BW)) bus ();

    shift_register #(
        .BW_DATA (BW),
        .RST_VAL (8'h00)
    ) u_dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [BW-1:0] obs,
                         input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then let the rising edge
    // happen and return just after it.
    task automatic step(input logic load, input logic [BW-1:0] d, input logic s);
        @(negedge i_clk);
        bus.i_load = load;
        bus.i_d    = d;
        bus.i_s    = s;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [7:0] stream;
        logic       rs;
        logic       rl;
        logic [7:0] rd;

        checks = 0;
        errors = 0;

        // 1. Reset with a pending load: takes effect before any clock edge.
        bus.i_load = 1'b1;
        bus.i_d    = 8'hFF;
        bus.i_s    = 1'b1;
        i_rst      = 1'b1;
        #1;
        check("reset_async", bus.o_q, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            check("reset_hold", bus.o_q, 8'h00);
        end

        // 2. Parallel load ignores i_s.
        @(negedge i_clk);
        i_rst = 1'b0;
        step(1'b1, 8'hA5, 1'b1);
        check("load_a5", bus.o_q, 8'hA5);

        // 3. Single shifts.
        step(1'b0, 8'h00, 1'b1);
        check("shift_d2", bus.o_q, 8'hD2);
        step(1'b0, 8'hFF, 1'b0);
        check("shift_69", bus.o_q, 8'h69);
        step(1'b0, 8'h00, 1'b0);
        check("shift_34", bus.o_q, 8'h34);

        // 4. Full replacement: first serial bit lands in bit 0.
        step(1'b1, 8'hFF, 1'b0);
        check("load_ff", bus.o_q, 8'hFF);
        stream = 8'b0100_1101; // bit i is the (i+1)-th serial bit applied
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, stream[i]);
        end
        check("replace_4d", bus.o_q, 8'h4D);

        // 5. Three shifts, then reload with i_s high, then release.
        step(1'b0, 8'h00, 1'b1);
        check("shift_a6", bus.o_q, 8'hA6);
        step(1'b0, 8'h00, 1'b1);
        check("shift_d3", bus.o_q, 8'hD3);
        step(1'b0, 8'h00, 1'b1);
        check("shift_e9", bus.o_q, 8'hE9);
        step(1'b1, 8'h3C, 1'b1);
        check("reload_3c", bus.o_q, 8'h3C);
        step(1'b0, 8'h3C, 1'b0);
        check("shift_1e", bus.o_q, 8'h1E);

        // 6. Random sequence against a reference model, with a reset pulse
        //    between edges part way through.
        mdl = 8'h1E;
        for (int c = 0; c < 20; c++) begin
            rs = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 7) == 0);
            rd = 8'($urandom_range(0, 255));
            step(rl, rd, rs);
            mdl = rl ? rd : {rs, mdl[7:1]};
            check("rand_model", bus.o_q, mdl);
            if (c == 9) begin
                #1;
                i_rst = 1'b1;
                #1;
                check("mid_reset_async", bus.o_q, 8'h00);
                #1;
                i_rst = 1'b0;
                mdl = 8'h00;
                step(1'b0, 8'h00, 1'b1);
                check("post_reset_80", bus.o_q, 8'h80);
                mdl = 8'h80;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
